mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported memory bus between the core's instruction-fetch port and its load/store port.
- Sits between the core and the unified memory. It produces per-port grant and valid pulses, which the core uses as its fetch-valid and memory-valid inputs.
- Non-pipelined: at most one transaction is outstanding downstream at any time. Data has priority over fetch by default.

Parameters:
- ADDR_WIDTH, 32, address width of all ports.
- DATA_WIDTH, 32, data width; byte-enable width is DATA_WIDTH/8.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- i_req  in  1  fetch request; held until i_gnt.
- i_addr  in  ADDR_WIDTH  fetch address; stable while i_req is high.
- i_gnt  out  1  fetch request accepted this cycle.
- i_valid  out  1  one-cycle pulse: i_rdata is valid.
- i_rdata  out  DATA_WIDTH  fetched word; registered.
- d_req  in  1  load/store request; held until d_gnt.
- d_we  in  1  1 = store.
- d_addr  in  ADDR_WIDTH  data address.
- d_wdata  in  DATA_WIDTH  store data.
- d_be  in  DATA_WIDTH/8  store byte enables.
- d_gnt  out  1  data request accepted this cycle.
- d_valid  out  1  one-cycle pulse: load data ready or store complete.
- d_rdata  out  DATA_WIDTH  load word; registered.
- mem_req  out  1  downstream request; held until mem_ack.
- mem_we  out  1  downstream write.
- mem_addr  out  ADDR_WIDTH  downstream address.
- mem_wdata  out  DATA_WIDTH  downstream write data.
- mem_be  out  DATA_WIDTH/8  downstream byte enables; all-ones for fetch.
- mem_ack  in  1  downstream completion; mem_rdata valid in the same cycle.
- mem_rdata  in  DATA_WIDTH  downstream read data.
- owner  out  2  debug: 0 = none, 1 = fetch, 2 = data.

Behaviour:
- FSM states: IDLE, IBUSY, DBUSY.
- Reset values: state=IDLE; mem_req, mem_we, i_valid, d_valid, i_gnt, d_gnt = 0; mem_addr, mem_wdata, mem_be, i_rdata, d_rdata = 0; owner = 0.
- Grant (IDLE only):
  - i_gnt and d_gnt are combinational: state==IDLE && req && winner.
  - Winner is data when d_req is high, else fetch.
  - On the grant edge, addr/we/wdata/be are latched into the mem_* registers and mem_req is set. State moves to DBUSY or IBUSY.
  - Fetch latches mem_we=0 and mem_be all-ones.
- Busy (IBUSY/DBUSY):
  - mem_req stays high with stable mem_* outputs until mem_ack.
  - No grants are issued while busy.
  - mem_ack may arrive in the first busy cycle (zero-wait memory) or any later cycle; there is no timeout.
- Completion: on the mem_ack edge:
  - mem_req clears.
  - mem_rdata is captured into i_rdata (IBUSY) or d_rdata (DBUSY, loads only; stores leave d_rdata unchanged).
  - The owner's valid pulses in the next cycle; state returns to IDLE in that same cycle.
- Back-to-back: the cycle carrying a valid pulse is an IDLE cycle, so a new grant can occur in it. Minimum 3 cycles per transaction: grant, ack, valid+grant.
- The requester must not change addr/data between asserting req and receiving gnt. After gnt it may present the next request immediately; that request waits for IDLE.
- mem_ack while mem_req==0 is ignored.
- Reset mid-transaction: return to IDLE, drop mem_req, emit no valid. The downstream memory shares rst, so no stale ack follows.
- owner reflects the state: IDLE=0, IBUSY=1, DBUSY=2.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: a 1-bit last-served register (reset: fetch) decides simultaneous i_req/d_req. The port not served last wins. The register updates on every grant.
- Undefined: fixed data-over-fetch priority; no last-served register is synthesized.

Decomposition:
- Shared package/header:
  - state encodings ARB_IDLE, ARB_IBUSY, ARB_DBUSY;
  - owner codes OWN_NONE, OWN_I, OWN_D.
- Sub-module arb_pick: combinational winner select from i_req, d_req and last-served, with fixed/round-robin selected under the macro.

Test Plan:
- Reset: hold rst 2 cycles with i_req=d_req=1 → no gnt; mem_req=0, owner=0; first gnt appears the cycle after rst drops.
- Fetch read, ack latency: i_req, i_addr=0x100 at cycle 0 → i_gnt in cycle 0. mem_req=1 with mem_addr=0x100, mem_we=0, mem_be=0xF in cycles 1–3. mem_ack with mem_rdata=0xDEADBEEF in cycle 3 → i_valid=1, i_rdata=0xDEADBEEF in cycle 4.
- Simultaneous requests, fixed priority: i_req and d_req (store: d_addr=0x200, d_wdata=0x12345678, d_be=0x3) both at cycle 0 → d_gnt in cycle 0; mem_we=1, mem_be=0x3. Zero-wait ack in cycle 1 → d_valid in cycle 2 with d_rdata unchanged, and i_gnt in cycle 2.
- Back-to-back loads with zero-wait ack → d_gnt in cycles 0, 2, 4; d_valid in cycles 2, 4, 6.
- Reset mid-transaction: rst in cycle 2 while in DBUSY, then mem_ack in cycle 3 → no d_valid; mem_req=0; owner=0.
- ARB_ROUND_ROBIN_EN, both requests held continuously → grant order D, I, D, I.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// ============================================================================
// mem_port_arbiter_pkg : shared state and owner encodings for the arbiter
// Revision 1.0
// ============================================================================
`default_nettype none

package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_IBUSY = 2'd1,
    ARB_DBUSY = 2'd2
  } arb_state_t;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_I    = 2'd1;
  localparam logic [1:0] OWN_D    = 2'd2;

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_arb_pick.sv
// ============================================================================
// arb_pick : fetch/data winner select; round-robin under ARB_ROUND_ROBIN_EN
// Revision 1.0
// ============================================================================
`default_nettype none

module arb_pick (
  input  logic i_req,
  input  logic d_req,
`ifdef ARB_ROUND_ROBIN_EN
  input  logic last_d,
`endif
  output logic pick_d
);

  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    // On a tie the port that was not served last wins.
    pick_d = d_req && !(i_req && last_d);
`else
    pick_d = d_req;
`endif
  end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter : shares one non-pipelined memory bus between fetch and
// load/store ports. Optional macro: ARB_ROUND_ROBIN_EN.  Revision 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_req,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  output logic                    i_gnt,
  output logic                    i_valid,
  output logic [DATA_WIDTH-1:0]   i_rdata,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_be,
  output logic                    d_gnt,
  output logic                    d_valid,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  input  logic                    mem_ack,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic [1:0]              owner
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;

  arb_state_t state, state_next;
  logic       pick_d;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_d <= 1'b0;
    end else if (i_gnt || d_gnt) begin
      last_d <= d_gnt;
    end
  end

  arb_pick u_pick (
    .i_req  (i_req),
    .d_req  (d_req),
    .last_d (last_d),
    .pick_d (pick_d)
  );
`else
  arb_pick u_pick (
    .i_req  (i_req),
    .d_req  (d_req),
    .pick_d (pick_d)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Grants are gated by rst so nothing is accepted while reset is held.
  always_comb begin
    state_next = state;
    i_gnt      = 1'b0;
    d_gnt      = 1'b0;
    owner      = OWN_NONE;
    case (state)
      ARB_IDLE: begin
        if (!rst) begin
          d_gnt = d_req && pick_d;
          i_gnt = i_req && !pick_d;
        end
        if (d_gnt) begin
          state_next = ARB_DBUSY;
        end else if (i_gnt) begin
          state_next = ARB_IBUSY;
        end
      end
      ARB_IBUSY: begin
        owner = OWN_I;
        if (mem_ack) begin
          state_next = ARB_IDLE;
        end
      end
      ARB_DBUSY: begin
        owner = OWN_D;
        if (mem_ack) begin
          state_next = ARB_IDLE;
        end
      end
      default: begin
        state_next = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      i_valid   <= 1'b0;
      d_valid   <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      i_valid <= 1'b0;
      d_valid <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (d_gnt) begin
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_be    <= d_be;
          end else if (i_gnt) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= i_addr;
            mem_be   <= {BE_WIDTH{1'b1}};
          end
        end
        ARB_IBUSY: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            i_rdata <= mem_rdata;
            i_valid <= 1'b1;
          end
        end
        ARB_DBUSY: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            d_valid <= 1'b1;
            if (!mem_we) begin
              d_rdata <= mem_rdata;
            end
          end
        end
        default: begin
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// tb_mem_port_arbiter : directed vector table, round-robin sequence and random
// traffic against a transaction-level model.  Revision 1.0
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, i_gnt, i_valid;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_gnt, d_valid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_be;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic [1:0]  owner;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_valid(i_valid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .owner(owner)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rst, ireq, dreq, dwe, ack;
    logic [31:0] rdata;
    logic        igt, dgt, mreq;
    logic [31:0] maddr;
    logic        mwe;
    logic [3:0]  mbe;
    logic [1:0]  own;
    logic        iv, dv;
    logic [31:0] ird, drd;
  } vec_t;

  vec_t tbl[22];

  // transaction-level model state for the random phase
  int          m_own;
  logic        m_iv, m_dv, m_last_d, ip, dp, eg_i, eg_d, nv_i, nv_d;
  logic [31:0] m_ird, m_drd, c_addr, c_wdata;
  logic        c_we;
  logic [3:0]  c_be;
  logic        got_d[$];
  logic        exp_d;
  int          cyc;

  initial begin
    //          rst ir dr we ak rdata         ig dg mr maddr     mwe mbe   own iv dv ird           drd
    tbl[0]  = '{1, 1, 1, 0, 0, 32'h0,        0, 0, 0, 32'h0,   0, 4'h0, 0, 0, 0, 32'h0,        32'h0};
    tbl[1]  = '{1, 1, 1, 0, 0, 32'h0,        0, 0, 0, 32'h0,   0, 4'h0, 0, 0, 0, 32'h0,        32'h0};
    tbl[2]  = '{0, 1, 1, 1, 0, 32'h0,        0, 1, 0, 32'h0,   0, 4'h0, 0, 0, 0, 32'h0,        32'h0};
    tbl[3]  = '{0, 1, 0, 1, 1, 32'hAAAA5555, 0, 0, 1, 32'h200, 1, 4'h3, 2, 0, 0, 32'h0,        32'h0};
    tbl[4]  = '{0, 1, 0, 0, 0, 32'h0,        1, 0, 0, 32'h0,   0, 4'h0, 0, 0, 1, 32'h0,        32'h0};
    tbl[5]  = '{0, 0, 0, 0, 0, 32'h0,        0, 0, 1, 32'h100, 0, 4'hF, 1, 0, 0, 32'h0,        32'h0};
    tbl[6]  = '{0, 0, 0, 0, 0, 32'h0,        0, 0, 1, 32'h100, 0, 4'hF, 1, 0, 0, 32'h0,        32'h0};
    tbl[7]  = '{0, 0, 0, 0, 1, 32'hDEADBEEF, 0, 0, 1, 32'h100, 0, 4'hF, 1, 0, 0, 32'h0,        32'h0};
    tbl[8]  = '{0, 0, 0, 0, 1, 32'h55555555, 0, 0, 0, 32'h0,   0, 4'h0, 0, 1, 0, 32'hDEADBEEF, 32'h0};
    tbl[9]  = '{0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,   0, 4'h0, 0, 0, 0, 32'h0,        32'h0};
    tbl[10] = '{0, 0, 1, 0, 0, 32'h0,        0, 1, 0, 32'h0,   0, 4'h0, 0, 0, 0, 32'h0,        32'h0};
    tbl[11] = '{0, 0, 1, 0, 1, 32'h11111111, 0, 0, 1, 32'h200, 0, 4'h3, 2, 0, 0, 32'h0,        32'h0};
    tbl[12] = '{0, 0, 1, 0, 0, 32'h0,        0, 1, 0, 32'h0,   0, 4'h0, 0, 0, 1, 32'h0,        32'h11111111};
    tbl[13] = '{0, 0, 1, 0, 1, 32'h22222222, 0, 0, 1, 32'h200, 0, 4'h3, 2, 0, 0, 32'h0,        32'h0};
    tbl[14] = '{0, 0, 1, 0, 0, 32'h0,        0, 1, 0, 32'h0,   0, 4'h0, 0, 0, 1, 32'h0,        32'h22222222};
    tbl[15] = '{0, 0, 0, 0, 1, 32'h33333333, 0, 0, 1, 32'h200, 0, 4'h3, 2, 0, 0, 32'h0,        32'h0};
    tbl[16] = '{0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,   0, 4'h0, 0, 0, 1, 32'h0,        32'h33333333};
    tbl[17] = '{0, 0, 1, 0, 0, 32'h0,        0, 1, 0, 32'h0,   0, 4'h0, 0, 0, 0, 32'h0,        32'h0};
    tbl[18] = '{0, 0, 0, 0, 0, 32'h0,        0, 0, 1, 32'h200, 0, 4'h3, 2, 0, 0, 32'h0,        32'h0};
    tbl[19] = '{1, 0, 0, 0, 0, 32'h0,        0, 0, 1, 32'h200, 0, 4'h3, 2, 0, 0, 32'h0,        32'h0};
    tbl[20] = '{0, 0, 0, 0, 1, 32'h44444444, 0, 0, 0, 32'h0,   0, 4'h0, 0, 0, 0, 32'h0,        32'h0};
    tbl[21] = '{0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,   0, 4'h0, 0, 0, 0, 32'h0,        32'h0};

    rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ack = 1'b0;
    i_addr = 32'h100; d_addr = 32'h200; d_wdata = 32'h12345678; d_be = 4'h3;
    mem_rdata = 32'h0;
    tick();

    // directed vectors
    for (int k = 0; k < 22; k++) begin
      tick();
      rst = tbl[k].rst; i_req = tbl[k].ireq; d_req = tbl[k].dreq;
      d_we = tbl[k].dwe; mem_ack = tbl[k].ack; mem_rdata = tbl[k].rdata;
      #2;
      chk($sformatf("v%0d i_gnt", k), 32'(i_gnt), 32'(tbl[k].igt));
      chk($sformatf("v%0d d_gnt", k), 32'(d_gnt), 32'(tbl[k].dgt));
      chk($sformatf("v%0d mem_req", k), 32'(mem_req), 32'(tbl[k].mreq));
      chk($sformatf("v%0d owner", k), 32'(owner), 32'(tbl[k].own));
      chk($sformatf("v%0d i_valid", k), 32'(i_valid), 32'(tbl[k].iv));
      chk($sformatf("v%0d d_valid", k), 32'(d_valid), 32'(tbl[k].dv));
      if (tbl[k].mreq) begin
        chk($sformatf("v%0d mem_addr", k), mem_addr, tbl[k].maddr);
        chk($sformatf("v%0d mem_we", k), 32'(mem_we), 32'(tbl[k].mwe));
        chk($sformatf("v%0d mem_be", k), 32'(mem_be), 32'(tbl[k].mbe));
        if (tbl[k].mwe) chk($sformatf("v%0d mem_wdata", k), mem_wdata, 32'h12345678);
      end
      if (tbl[k].iv) chk($sformatf("v%0d i_rdata", k), i_rdata, tbl[k].ird);
      if (tbl[k].dv) chk($sformatf("v%0d d_rdata", k), d_rdata, tbl[k].drd);
    end

    // both ports held continuously with zero-wait memory: grant order
    i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    cyc = 0;
    while (got_d.size() < 4 && cyc < 40) begin
      tick();
      mem_ack = mem_req;
      #2;
      if (i_gnt && d_gnt) chk("rr both_gnt", 32'd1, 32'd0);
      else if (d_gnt) got_d.push_back(1'b1);
      else if (i_gnt) got_d.push_back(1'b0);
      cyc++;
    end
    if (got_d.size() < 4) chk("rr timeout", 32'(got_d.size()), 32'd4);
    for (int g = 0; g < got_d.size(); g++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_d = (g % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      chk($sformatf("rr grant%0d is_data", g), 32'(got_d[g]), 32'(exp_d));
    end

    // drain and reset before random traffic
    i_req = 1'b0; d_req = 1'b0;
    for (int w = 0; w < 3; w++) begin
      tick();
      mem_ack = 1'b1;
    end
    tick();
    rst = 1'b1; mem_ack = 1'b0;
    tick();

    m_own = 0; m_iv = 0; m_dv = 0; m_ird = 0; m_drd = 0; m_last_d = 0; ip = 0; dp = 0;
    c_we = 0; c_addr = 0; c_wdata = 0; c_be = 0;
    for (int n = 0; n < 2000; n++) begin
      tick();
      rst = 1'b0;
      if (!i_req || ip) begin
        i_req = 1'($urandom_range(0, 1));
        i_addr = $urandom;
      end
      if (!d_req || dp) begin
        d_req = 1'($urandom_range(0, 1));
        d_we = 1'($urandom_range(0, 1));
        d_addr = $urandom; d_wdata = $urandom; d_be = 4'($urandom);
      end
      mem_ack = ($urandom_range(0, 2) == 0);
      mem_rdata = $urandom;
      #2;
`ifdef ARB_ROUND_ROBIN_EN
      eg_d = (m_own == 0) && d_req && !(i_req && m_last_d);
`else
      eg_d = (m_own == 0) && d_req;
`endif
      eg_i = (m_own == 0) && i_req && !eg_d;
      chk("rnd i_gnt", 32'(i_gnt), 32'(eg_i));
      chk("rnd d_gnt", 32'(d_gnt), 32'(eg_d));
      chk("rnd mem_req", 32'(mem_req), 32'(m_own != 0));
      chk("rnd owner", 32'(owner), 32'(m_own));
      chk("rnd i_valid", 32'(i_valid), 32'(m_iv));
      chk("rnd d_valid", 32'(d_valid), 32'(m_dv));
      if (m_iv) chk("rnd i_rdata", i_rdata, m_ird);
      if (m_dv) chk("rnd d_rdata", d_rdata, m_drd);
      if (m_own != 0) begin
        chk("rnd mem_addr", mem_addr, c_addr);
        chk("rnd mem_we", 32'(mem_we), 32'(c_we));
        chk("rnd mem_be", 32'(mem_be), 32'(c_be));
        if (c_we) chk("rnd mem_wdata", mem_wdata, c_wdata);
      end
      nv_i = 1'b0; nv_d = 1'b0;
      if (m_own == 1 && mem_ack) begin
        m_ird = mem_rdata; nv_i = 1'b1; m_own = 0;
      end else if (m_own == 2 && mem_ack) begin
        if (!c_we) m_drd = mem_rdata;
        nv_d = 1'b1; m_own = 0;
      end else if (m_own == 0) begin
        if (eg_d) begin
          m_own = 2; c_we = d_we; c_addr = d_addr; c_wdata = d_wdata; c_be = d_be;
          m_last_d = 1'b1;
        end else if (eg_i) begin
          m_own = 1; c_we = 1'b0; c_addr = i_addr; c_be = 4'hF;
          m_last_d = 1'b0;
        end
      end
      m_iv = nv_i; m_dv = nv_d;
      ip = eg_i; dp = eg_d;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
